// File: rtl/conv3x3_filter.sv
// conv3x3_filter: 3x3 convolution on a vid_io pixel stream.
// Each of the three CW-bit channels is filtered independently with one of
// four kernels (Gaussian blur, Sobel-X, Sobel-Y, sharpen) or passed through.
// Two ping-pong line buffers supply rows r-2 and r-1. A three-column window
// is centred one row up and one column left of the newest pixel.
// The kernel is latched only on a vsync rising edge, so a frame never mixes
// kernels.
// Optional build macro: CONV_BORDER_ZERO_EN. When it is defined, border
// pixels in the filtering modes output zero instead of the centre pixel.
module conv3x3_filter #(
  parameter int DATA_WIDTH = 24,
  parameter int MAX_LINE   = 2048,
  parameter int LATENCY    = 4      // must be 3 or more
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_WIDTH-1:0] i_vid_data,
  input  logic                  i_vid_hsync,
  input  logic                  i_vid_vsync,
  input  logic                  i_vid_VDE,
  output logic [DATA_WIDTH-1:0] o_vid_data,
  output logic                  o_vid_hsync,
  output logic                  o_vid_vsync,
  output logic                  o_vid_VDE,
  input  logic [2:0]            mode,
  output logic [2:0]            active_mode
);

  localparam int CW    = DATA_WIDTH / 3;
  localparam int AW    = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
  localparam int COL_W = AW + 1;   // one spare bit so columns past the buffer stay visible
  localparam int ROW_W = 16;
  localparam int SW    = CW + 6;   // signed headroom for the largest kernel sum
  localparam int ODLY  = LATENCY - 2;

  localparam logic [COL_W-1:0] MAX_COL = COL_W'(MAX_LINE);
  localparam logic [COL_W-1:0] COL_TWO = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO = ROW_W'(2);
  localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);
  localparam logic signed [SW-1:0] MAXV = SW'((64'd1 << CW) - 64'd1);

  // Zero-extend an unsigned channel sample into the signed working width.
  function automatic logic signed [SW-1:0] ext(input logic [CW-1:0] v);
    return $signed({{(SW-CW){1'b0}}, v});
  endfunction

  // Magnitude, divide by four, saturate to the channel maximum.
  function automatic logic [CW-1:0] sat_abs_shr2(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] a;
    a = (v < 0) ? -v : v;
    a = a >>> 2;
    if (a > MAXV) return {CW{1'b1}};
    return a[CW-1:0];
  endfunction

  // Clamp a signed sum into [0, channel maximum].
  function automatic logic [CW-1:0] clamp_u(input logic signed [SW-1:0] v);
    if (v < 0)    return '0;
    if (v > MAXV) return {CW{1'b1}};
    return v[CW-1:0];
  endfunction

  // One channel through the selected kernel.
  // p[3*row+col]: row 0 is the top (r-2), col 0 is the left (c-2).
  function automatic logic [CW-1:0] filt_ch(input logic [2:0] md,
                                            input logic [8:0][CW-1:0] p);
    logic signed [SW-1:0] s;
    s = '0;
    case (md)
      3'b001: begin
        s = ext(p[0]) + (ext(p[1]) <<< 1) + ext(p[2])
          + (ext(p[3]) <<< 1) + (ext(p[4]) <<< 2) + (ext(p[5]) <<< 1)
          + ext(p[6]) + (ext(p[7]) <<< 1) + ext(p[8]);
        s = s >>> 4;
        return s[CW-1:0];
      end
      3'b010: begin
        s = (ext(p[2]) + (ext(p[5]) <<< 1) + ext(p[8]))
          - (ext(p[0]) + (ext(p[3]) <<< 1) + ext(p[6]));
        return sat_abs_shr2(s);
      end
      3'b011: begin
        s = (ext(p[6]) + (ext(p[7]) <<< 1) + ext(p[8]))
          - (ext(p[0]) + (ext(p[1]) <<< 1) + ext(p[2]));
        return sat_abs_shr2(s);
      end
      3'b100: begin
        s = (ext(p[4]) <<< 2) + ext(p[4])
          - ext(p[1]) - ext(p[7]) - ext(p[3]) - ext(p[5]);
        return clamp_u(s);
      end
      default: return p[4];
    endcase
  endfunction

  // Stream position tracking.
  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic             vde_d;
  logic             vs_d;
  logic             frame_ok;   // set once a vsync edge has re-anchored the row count
  logic             vde_fall;
  logic             vs_rise;
  logic             in_range;
  logic             wr_en;
  logic [AW-1:0]    addr;

  assign vde_fall = vde_d && !i_vid_VDE;
  assign vs_rise  = i_vid_vsync && !vs_d;
  assign in_range = (col_cnt < MAX_COL);
  assign wr_en    = i_vid_VDE && in_range;
  assign addr     = col_cnt[AW-1:0];

  // Line buffers (contents are never reset; the border rule masks stale data).
  logic [DATA_WIDTH-1:0] lbuf0 [MAX_LINE];
  logic [DATA_WIDTH-1:0] lbuf1 [MAX_LINE];

  // Pipeline registers.
  logic [DATA_WIDTH-1:0] rd0_p0, rd1_p0;
  logic [DATA_WIDTH-1:0] px_p0, px_p1;
  logic                  brd_p0, brd_p1;
  logic                  rsel_p0;
  logic [2:0]            md_p0, md_p1;
  logic [DATA_WIDTH-1:0] up1_p0, up2_p0;
  logic [2:0][2:0][DATA_WIDTH-1:0] win_p1;   // [col][row], col 2 = newest, row 2 = bottom
  logic [2:0][8:0][CW-1:0]         tap_p1;
  logic [DATA_WIDTH-1:0] filt_p1;
  logic [DATA_WIDTH-1:0] res_p1;
  logic                  vde_p1;
  logic                  filt_mode_p1;
  logic [ODLY-1:0][DATA_WIDTH-1:0] dat_p2;
  logic [LATENCY-1:0][2:0]         sync_p;   // {hsync, vsync, VDE} per stage

  // Column/row counters, edge detectors and the frame-boundary mode latch.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      col_cnt     <= '0;
      row_cnt     <= '0;
      vde_d       <= 1'b0;
      vs_d        <= 1'b0;
      frame_ok    <= 1'b0;
      active_mode <= 3'b000;
    end else begin
      vde_d <= i_vid_VDE;
      vs_d  <= i_vid_vsync;
      if (i_vid_VDE) begin
        if (col_cnt != {COL_W{1'b1}}) col_cnt <= col_cnt + COL_ONE;
      end else if (vde_fall) begin
        col_cnt <= '0;
      end
      if (vs_rise)       row_cnt <= '0;
      else if (vde_fall) row_cnt <= row_cnt + ROW_ONE;
      if (vs_rise) begin
        frame_ok    <= 1'b1;
        active_mode <= mode;
      end
    end
  end

  // ---- stage p0: line buffer 0, read-before-write gives row r-2 or r-1
  always_ff @(posedge clk) begin
    if (wr_en) begin
      rd0_p0 <= lbuf0[addr];
      if (!row_cnt[0]) lbuf0[addr] <= i_vid_data;
    end
  end

  // ---- stage p0: line buffer 1, same scheme on the odd rows
  always_ff @(posedge clk) begin
    if (wr_en) begin
      rd1_p0 <= lbuf1[addr];
      if (row_cnt[0]) lbuf1[addr] <= i_vid_data;
    end
  end

  // ---- stage p0: capture the pixel, its border status and kernel
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      px_p0   <= '0;
      brd_p0  <= 1'b1;
      rsel_p0 <= 1'b0;
      md_p0   <= 3'b000;
    end else begin
      px_p0   <= i_vid_data;
      brd_p0  <= !frame_ok || (row_cnt < ROW_TWO) || (col_cnt < COL_TWO) || !in_range;
      rsel_p0 <= row_cnt[0];
      md_p0   <= active_mode;
    end
  end

  // The buffer being written holds row r-2; the other one holds row r-1.
  always_comb begin
    up2_p0 = rsel_p0 ? rd1_p0 : rd0_p0;
    up1_p0 = rsel_p0 ? rd0_p0 : rd1_p0;
  end

  // ---- stage p1: shift the 3x3 window one column
  always_ff @(posedge clk) begin
    win_p1[0] <= win_p1[1];
    win_p1[1] <= win_p1[2];
    win_p1[2] <= {px_p0, up1_p0, up2_p0};
  end

  // ---- stage p1: carry pixel, border flag and kernel alongside the window
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      px_p1  <= '0;
      brd_p1 <= 1'b1;
      md_p1  <= 3'b000;
    end else begin
      px_p1  <= px_p0;
      brd_p1 <= brd_p0;
      md_p1  <= md_p0;
    end
  end

  // Per-channel kernel evaluation on the current window.
  always_comb begin
    tap_p1  = '0;
    filt_p1 = '0;
    for (int ch = 0; ch < 3; ch++) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          tap_p1[ch][3*r+c] = win_p1[c][r][ch*CW +: CW];
        end
      end
      filt_p1[ch*CW +: CW] = filt_ch(md_p1, tap_p1[ch]);
    end
  end

  assign vde_p1       = sync_p[1][0];
  assign filt_mode_p1 = (md_p1 >= 3'b001) && (md_p1 <= 3'b100);

  // Choose passthrough, border value or filtered pixel.
  always_comb begin
    res_p1 = px_p1;
    if (vde_p1 && filt_mode_p1) begin
      if (brd_p1) begin
`ifdef CONV_BORDER_ZERO_EN
        res_p1 = '0;
`else
        res_p1 = px_p1;
`endif
      end else begin
        res_p1 = filt_p1;
      end
    end
  end

  // ---- stage p2: register the result and pad out to LATENCY
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      dat_p2 <= '0;
    end else begin
      dat_p2[0] <= res_p1;
      for (int i = 1; i < ODLY; i++) dat_p2[i] <= dat_p2[i-1];
    end
  end

  // Sync delay line, exactly LATENCY stages in every mode.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync_p <= '0;
    end else begin
      sync_p[0] <= {i_vid_hsync, i_vid_vsync, i_vid_VDE};
      for (int i = 1; i < LATENCY; i++) sync_p[i] <= sync_p[i-1];
    end
  end

  assign o_vid_data  = dat_p2[ODLY-1];
  assign o_vid_hsync = sync_p[LATENCY-1][2];
  assign o_vid_vsync = sync_p[LATENCY-1][1];
  assign o_vid_VDE   = sync_p[LATENCY-1][0];

endmodule

// File: tb/tb_conv3x3_filter.sv
// Testbench for conv3x3_filter: frames of directed and random pixels,
// compared each cycle against an image-level reference model.
module tb_conv3x3_filter;
  localparam int DW  = 24;
  localparam int ML  = 16;
  localparam int LAT = 4;
  localparam int W   = 20;
  localparam int H   = 6;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [DW-1:0] i_vid_data, o_vid_data;
  logic          i_vid_hsync, i_vid_vsync, i_vid_VDE;
  logic          o_vid_hsync, o_vid_vsync, o_vid_VDE;
  logic [2:0]    mode, active_mode;

  always #5 clk = ~clk;

  conv3x3_filter #(.DATA_WIDTH(DW), .MAX_LINE(ML), .LATENCY(LAT)) dut (
    .clk(clk), .n_rst(n_rst),
    .i_vid_data(i_vid_data), .i_vid_hsync(i_vid_hsync),
    .i_vid_vsync(i_vid_vsync), .i_vid_VDE(i_vid_VDE),
    .o_vid_data(o_vid_data), .o_vid_hsync(o_vid_hsync),
    .o_vid_vsync(o_vid_vsync), .o_vid_VDE(o_vid_VDE),
    .mode(mode), .active_mode(active_mode)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          hs;
    logic          vs;
    logic          de;
  } ent_t;

  ent_t          expq[$];
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] img [0:H-1][0:W-1];
  int kern [1:4][0:2][0:2] = '{
    '{'{ 1, 2, 1}, '{ 2, 4, 2}, '{ 1, 2, 1}},
    '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}},
    '{'{-1,-2,-1}, '{ 0, 0, 0}, '{ 1, 2, 1}},
    '{'{ 0,-1, 0}, '{-1, 5,-1}, '{ 0,-1, 0}}};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected output pixel for input position (r,c) under kernel m.
  function automatic logic [DW-1:0] model(input int r, input int c, input int m);
    logic [DW-1:0] res;
    int acc, v, p;
    if (m < 1 || m > 4) return img[r][c];
    if (r < 2 || c < 2 || c >= ML) begin
`ifdef CONV_BORDER_ZERO_EN
      return '0;
`else
      return img[r][c];
`endif
    end
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      acc = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          p = int'((img[r-2+i][c-2+j] >> (8*ch)) & 24'hFF);
          acc += kern[m][i][j] * p;
        end
      case (m)
        1:       v = acc / 16;
        2, 3:    begin v = ((acc < 0) ? -acc : acc) / 4; if (v > 255) v = 255; end
        default: v = (acc < 0) ? 0 : ((acc > 255) ? 255 : acc);
      endcase
      res[8*ch +: 8] = 8'(v);
    end
    return res;
  endfunction

  // One clock: drive inputs, then check the output for the entry LAT cycles old.
  task automatic step(input logic [DW-1:0] d, input logic hs, input logic vs,
                      input logic de, input logic [DW-1:0] ed, input logic rn);
    ent_t e;
    i_vid_data = d; i_vid_hsync = hs; i_vid_vsync = vs; i_vid_VDE = de; n_rst = rn;
    @(posedge clk);
    #1;
    if (!rn) begin
      chk("rst_data", 32'(o_vid_data), 32'h0);
      chk("rst_sync", 32'({o_vid_hsync, o_vid_vsync, o_vid_VDE}), 32'h0);
      chk("rst_mode", 32'(active_mode), 32'h0);
      expq.delete();
      repeat (LAT-1) expq.push_back('0);
    end else begin
      expq.push_back({ed, hs, vs, de});
      if (expq.size() >= LAT) begin
        e = expq.pop_front();
        chk("data",  32'(o_vid_data),  32'(e.d));
        chk("hsync", 32'(o_vid_hsync), 32'(e.hs));
        chk("vsync", 32'(o_vid_vsync), 32'(e.vs));
        chk("vde",   32'(o_vid_VDE),   32'(e.de));
      end
    end
  endtask

  task automatic idle(input int n);
    logic [DW-1:0] b;
    for (int k = 0; k < n; k++) begin
      b = DW'($urandom);
      step(b, 1'b0, 1'b0, 1'b0, b, 1'b1);
    end
  endtask

  // One frame: vsync, H lines of W pixels. mid_mode >= 0 changes mode at row 2;
  // rst_r >= 0 pulses reset on pixel (rst_r, rst_c).
  task automatic run_frame(input int pat, input int mid_mode, input int rst_r, input int rst_c);
    int am;
    logic [DW-1:0] b;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (pat)
          0:       img[r][c] = DW'((r*W + c) * 32'h010101);
          1:       img[r][c] = 24'h404040;
          2:       img[r][c] = (c < 10) ? 24'h000000 : 24'hFFFFFF;
          3:       img[r][c] = ((r + c) % 2 != 0) ? 24'hFFFFFF : 24'h808080;
          4:       img[r][c] = ((r + c) % 2 != 0) ? 24'hFFFFFF : 24'h000000;
          default: img[r][c] = DW'($urandom);
        endcase
    am = int'(mode);
    for (int k = 0; k < 2; k++) begin
      b = DW'($urandom);
      step(b, 1'b0, 1'b1, 1'b0, b, 1'b1);
      if (k == 0) chk("mode_latch", 32'(active_mode), 32'(am));
    end
    idle(2);
    for (int r = 0; r < H; r++) begin
      for (int k = 0; k < 3; k++) begin
        b = DW'($urandom);
        step(b, (k < 2), 1'b0, 1'b0, b, 1'b1);
      end
      for (int c = 0; c < W; c++) begin
        if (r == 2 && c == 0 && mid_mode >= 0) mode = 3'(mid_mode);
        if (r == rst_r && c == rst_c) begin
          step(img[r][c], 1'b0, 1'b0, 1'b1, '0, 1'b0);
          am = 0;
        end else begin
          step(img[r][c], 1'b0, 1'b0, 1'b1, model(r, c, am), 1'b1);
        end
        if (r == 2 && c == 0 && mid_mode >= 0) chk("mode_hold", 32'(active_mode), 32'(am));
      end
    end
    idle(4);
    chk("mode_end", 32'(active_mode), 32'(am));
  endtask

  initial begin
    i_vid_data = '0; i_vid_hsync = 0; i_vid_vsync = 0; i_vid_VDE = 0;
    n_rst = 0; mode = 3'b000;
    for (int k = 0; k < 3; k++) step('0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle(3);
    // passthrough of a ramp
    mode = 3'b000; run_frame(0, -1, -1, 0);
    // blur of a flat field
    mode = 3'b001; run_frame(1, -1, -1, 0);
    // Sobel-X and Sobel-Y on a vertical edge
    mode = 3'b010; run_frame(2, -1, -1, 0);
    mode = 3'b011; run_frame(2, -1, -1, 0);
    // sharpen clamping both ways
    mode = 3'b100; run_frame(3, -1, -1, 0);
    mode = 3'b100; run_frame(4, -1, -1, 0);
    // mode change mid-frame takes effect only on the next frame
    mode = 3'b000; run_frame(5, 3, -1, 0);
    run_frame(5, -1, -1, 0);
    // one-cycle reset mid-line, then a frame with border passthrough on rows 0-1
    mode = 3'b001; run_frame(5, -1, 3, 7);
    run_frame(5, -1, -1, 0);
    // random kernels on random frames
    for (int f = 0; f < 5; f++) begin
      mode = 3'($urandom_range(0, 7));
      run_frame(5, -1, -1, 0);
    end
    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
